// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC + internal instruction memory fetch stage with stall, branch
//            redirect, halt-on-opcode and an idle-time program-load port.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int         ADDR_W  = 5,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [1:0]        S_IDLE  = 2'd0;
    localparam logic [1:0]        S_FETCH = 2'd1;
    localparam logic [1:0]        S_HALT  = 2'd2;
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_word;
    logic              mem_we;
    logic              rd_is_halt;

    assign rd_word    = mem[pc];
    assign rd_is_halt = (rd_word[DATA_W-1 -: 4] == HALT_OP);
    // Memory is write-protected while fetching so a running program cannot be torn.
    assign mem_we     = load_en && (state != S_FETCH);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (branch_en) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instr       <= rd_word;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_ONE;
                        if (rd_is_halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state       <= S_FETCH;
                        halted      <= 1'b0;
                        pc          <= '0;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        // Halt word is retired on the first unstalled cycle.
                        instr_valid <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pc          <= '0;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
